// File: rtl/cpu_core.sv
// cpu_core: single-cycle 32-bit processor.
// One instruction is fetched, executed and retired per clock cycle.
// Instruction and data memories are external and read combinationally.
module cpu_core #(
  parameter int REGS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] inst_mem_data_i,
  output logic [31:0] inst_mem_address_o,
  input  logic [31:0] data_mem_out_data_i,
  output logic [31:0] data_mem_address_o,
  output logic [31:0] data_mem_in_data_o,
  output logic        data_mem_WE_o
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LUI  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q [REGS];

  logic [3:0]  opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] simm, rs1_val, rs2_val, ea;
  logic        wr_en;
  logic [31:0] wr_val;

  assign opcode = inst_mem_data_i[31:28];
  assign rd     = inst_mem_data_i[27:24];
  assign rs1    = inst_mem_data_i[23:20];
  assign rs2    = inst_mem_data_i[19:16];
  assign imm    = inst_mem_data_i[15:0];
  assign simm   = {{16{imm[15]}}, imm};

  // R0 reads as zero regardless of what the array slot holds
  assign rs1_val = (rs1 == 4'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 4'd0) ? 32'd0 : rf_q[rs2];
  assign ea      = rs1_val + simm;

  assign inst_mem_address_o = pc_q;
  assign data_mem_address_o = ea;
  assign data_mem_in_data_o = rs2_val;
  // Gated by RST directly so no store can leak out while reset is asserted
  assign data_mem_WE_o      = (opcode == OP_SW) && !halted_q && !RST;

  // Decode and execute: next PC, halt flag and register write-back
  always_comb begin
    pc_d     = pc_q + 32'd1;
    halted_d = halted_q;
    wr_en    = 1'b0;
    wr_val   = 32'd0;
    case (opcode)
      OP_NOP:  ;
      OP_ADD:  begin wr_en = 1'b1; wr_val = rs1_val + rs2_val; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rs1_val - rs2_val; end
      OP_AND:  begin wr_en = 1'b1; wr_val = rs1_val & rs2_val; end
      OP_OR:   begin wr_en = 1'b1; wr_val = rs1_val | rs2_val; end
      OP_XOR:  begin wr_en = 1'b1; wr_val = rs1_val ^ rs2_val; end
      OP_SLL:  begin wr_en = 1'b1; wr_val = rs1_val << rs2_val[4:0]; end
      OP_SRL:  begin wr_en = 1'b1; wr_val = rs1_val >> rs2_val[4:0]; end
      OP_ADDI: begin wr_en = 1'b1; wr_val = ea; end
      OP_LUI:  begin wr_en = 1'b1; wr_val = {imm, 16'h0000}; end
      OP_LW:   begin wr_en = 1'b1; wr_val = data_mem_out_data_i; end
      OP_SW:   ;
      OP_BEQ:  if (rs1_val == rs2_val) pc_d = pc_q + 32'd1 + simm;
      OP_BNE:  if (rs1_val != rs2_val) pc_d = pc_q + 32'd1 + simm;
      OP_JMP:  pc_d = {16'h0000, imm};
      OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
      default: ;
    endcase
    // Once halted, the core is frozen until reset
    if (halted_q) begin
      pc_d  = pc_q;
      wr_en = 1'b0;
    end
  end

  // Program counter and halt flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Register file; slot 0 is never written so R0 stays zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= 32'd0;
    end else if (wr_en && (rd != 4'd0)) begin
      rf_q[rd] <= wr_val;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: directed programs plus random programs, all run
// in lockstep with an instruction-level reference model.
module tb_cpu_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] inst_mem_data_i, inst_mem_address_o;
  logic [31:0] data_mem_out_data_i, data_mem_address_o, data_mem_in_data_o;
  logic        data_mem_WE_o;

  logic [31:0] imem   [256];
  logic [31:0] dmem   [256];
  logic [31:0] m_reg  [16];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc;
  logic        m_halt;

  logic [31:0] obs_pc [128];
  logic [31:0] obs_addr [128];
  logic [31:0] obs_data [128];
  logic        obs_we [128];

  int n_chk  = 0;
  int n_fail = 0;

  cpu_core #(.REGS(16)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .inst_mem_data_i     (inst_mem_data_i),
    .inst_mem_address_o  (inst_mem_address_o),
    .data_mem_out_data_i (data_mem_out_data_i),
    .data_mem_address_o  (data_mem_address_o),
    .data_mem_in_data_o  (data_mem_in_data_o),
    .data_mem_WE_o       (data_mem_WE_o)
  );

  always #5 CLK = ~CLK;

  assign inst_mem_data_i     = imem[inst_mem_address_o[7:0]];
  assign data_mem_out_data_i = dmem[data_mem_address_o[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    m_pc   = 32'd0;
    m_halt = 1'b0;
  endtask

  // Assert RST now, check the reset outputs, hold over one rising edge, release
  task automatic do_reset(input string name);
    RST = 1'b1;
    #1;
    chk({name, " rst pc"}, inst_mem_address_o, 32'd0);
    chk({name, " rst we"}, {31'd0, data_mem_WE_o}, 32'd0);
    @(posedge CLK);
    #1;
    chk({name, " rst pc hold"}, inst_mem_address_o, 32'd0);
    chk({name, " rst we hold"}, {31'd0, data_mem_WE_o}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    model_reset();
  endtask

  // Run n cycles comparing DUT outputs to the ISA model, one instruction per cycle
  task automatic run(input int n, input string name);
    logic [31:0] inst, simm, a, b, ea, res, npc;
    logic [3:0]  op, rd, rs1, rs2;
    logic        wr, e_we;
    for (int c = 0; c < n; c++) begin
      inst = imem[m_pc[7:0]];
      op   = inst[31:28];
      rd   = inst[27:24];
      rs1  = inst[23:20];
      rs2  = inst[19:16];
      simm = {{16{inst[15]}}, inst[15:0]};
      a    = m_reg[rs1];
      b    = m_reg[rs2];
      ea   = a + simm;
      e_we = (op == 4'hB) && !m_halt;

      chk($sformatf("%s pc c%0d", name, c), inst_mem_address_o, m_pc);
      chk($sformatf("%s we c%0d", name, c), {31'd0, data_mem_WE_o}, {31'd0, e_we});
      chk($sformatf("%s addr c%0d", name, c), data_mem_address_o, ea);
      chk($sformatf("%s wdata c%0d", name, c), data_mem_in_data_o, b);

      if (c < 128) begin
        obs_pc[c]   = inst_mem_address_o;
        obs_we[c]   = data_mem_WE_o;
        obs_addr[c] = data_mem_address_o;
        obs_data[c] = data_mem_in_data_o;
      end

      // External memory commits the store at the coming rising edge
      if (data_mem_WE_o === 1'b1) dmem[data_mem_address_o[7:0]] = data_mem_in_data_o;

      if (!m_halt) begin
        res = 32'd0;
        wr  = 1'b1;
        npc = m_pc + 32'd1;
        case (op)
          4'h0: wr = 1'b0;
          4'h1: res = a + b;
          4'h2: res = a - b;
          4'h3: res = a & b;
          4'h4: res = a | b;
          4'h5: res = a ^ b;
          4'h6: res = a << b[4:0];
          4'h7: res = a >> b[4:0];
          4'h8: res = ea;
          4'h9: res = {inst[15:0], 16'h0000};
          4'hA: res = m_dmem[ea[7:0]];
          4'hB: begin wr = 1'b0; m_dmem[ea[7:0]] = b; end
          4'hC: begin wr = 1'b0; if (a == b) npc = m_pc + 32'd1 + simm; end
          4'hD: begin wr = 1'b0; if (a != b) npc = m_pc + 32'd1 + simm; end
          4'hE: begin wr = 1'b0; npc = {16'h0000, inst[15:0]}; end
          default: begin wr = 1'b0; npc = m_pc; m_halt = 1'b1; end
        endcase
        if (wr && rd != 4'd0) m_reg[rd] = res;
        m_pc = npc;
      end

      @(negedge CLK);
      #1;
    end
  endtask

  // Random body with forward-only control flow, then dump R1..R15, then HALT
  task automatic gen_prog(input int body);
    int k;
    logic [3:0] op;
    clear_imem();
    for (int p = 0; p < body; p++) begin
      k = $urandom_range(0, 13);
      if (k <= 11) begin
        op = k[3:0];
        imem[p] = ins(op, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
      end else if (k == 12) begin
        op = ($urandom_range(0, 1) == 0) ? 4'hC : 4'hD;
        imem[p] = ins(op, 4'd0, 4'($urandom), 4'($urandom),
                      16'($urandom_range(0, body - 1 - p)));
      end else begin
        imem[p] = ins(4'hE, 4'd0, 4'd0, 4'd0, 16'($urandom_range(p + 1, body)));
      end
    end
    for (int r = 1; r < 16; r++)
      imem[body + r - 1] = ins(4'hB, 4'd0, 4'd0, 4'(r), 16'(200 + r));
    imem[body + 15] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  initial begin
    int mism;
    int any_we;
    for (int i = 0; i < 256; i++) begin
      dmem[i]   = $urandom;
      m_dmem[i] = dmem[i];
    end
    clear_imem();
    model_reset();
    @(negedge CLK);

    // ADDI/ADDI/ADD/SW: store of 12 to address 10 in the fourth cycle
    imem[0] = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd5);
    imem[1] = ins(4'h8, 4'd2, 4'd0, 4'd0, 16'd7);
    imem[2] = ins(4'h1, 4'd3, 4'd1, 4'd2, 16'd0);
    imem[3] = ins(4'hB, 4'd0, 4'd0, 4'd3, 16'd10);
    do_reset("r29");
    run(5, "r29");
    chk("r29 sw we", {31'd0, obs_we[3]}, 32'd1);
    chk("r29 sw addr", obs_addr[3], 32'd10);
    chk("r29 sw data", obs_data[3], 32'd12);

    // LUI then negative ADDI
    clear_imem();
    imem[0] = ins(4'h9, 4'd1, 4'd0, 4'd0, 16'hFFFF);
    imem[1] = ins(4'h8, 4'd1, 4'd1, 4'd0, 16'hFFFF);
    imem[2] = ins(4'hB, 4'd0, 4'd0, 4'd1, 16'd0);
    do_reset("r30");
    run(4, "r30");
    chk("r30 sw data", obs_data[2], 32'hFFFE_FFFF);
    chk("r30 sw addr", obs_addr[2], 32'd0);

    // LW then SW of the loaded value
    clear_imem();
    dmem[20]   = 32'h0000_1234;
    m_dmem[20] = 32'h0000_1234;
    imem[0] = ins(4'hA, 4'd4, 4'd0, 4'd0, 16'd20);
    imem[1] = ins(4'hB, 4'd0, 4'd0, 4'd4, 16'd21);
    do_reset("r31");
    run(3, "r31");
    chk("r31 sw addr", obs_addr[1], 32'd21);
    chk("r31 sw data", obs_data[1], 32'h0000_1234);
    chk("r31 mem", dmem[21], 32'h0000_1234);

    // BNE to itself: spins while taken, falls through when not
    clear_imem();
    imem[0] = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd1);
    imem[3] = ins(4'hD, 4'd0, 4'd1, 4'd0, 16'hFFFF);
    do_reset("r32a");
    run(8, "r32a");
    chk("r32 spin pc", obs_pc[7], 32'd3);
    imem[0] = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd0);
    do_reset("r32b");
    run(6, "r32b");
    chk("r32 fall pc", obs_pc[4], 32'd4);

    // HALT at 6 freezes PC and stores; SW after it must never fire
    clear_imem();
    imem[6] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    imem[7] = ins(4'hB, 4'd0, 4'd0, 4'd0, 16'd3);
    do_reset("r33");
    run(17, "r33");
    any_we = 0;
    for (int c = 6; c < 17; c++) if (obs_we[c] !== 1'b0) any_we++;
    chk("r33 halt pc", obs_pc[16], 32'd6);
    chk("r33 halt we", any_we, 0);

    // Self-jump loops in place
    clear_imem();
    imem[2] = ins(4'hE, 4'd0, 4'd0, 4'd0, 16'd2);
    do_reset("r25");
    run(6, "r25");
    chk("r25 self jmp", obs_pc[5], 32'd2);

    // Backward branch below zero wraps the PC modulo 2^32
    clear_imem();
    imem[0] = ins(4'hC, 4'd0, 4'd0, 4'd0, 16'hFFFE);
    do_reset("wrap");
    run(3, "wrap");
    chk("wrap pc hi", obs_pc[1], 32'hFFFF_FFFF);
    chk("wrap pc zero", obs_pc[2], 32'd0);

    // Reset in mid-program between two stores; R1 must read zero afterwards
    clear_imem();
    imem[0] = ins(4'hB, 4'd0, 4'd0, 4'd1, 16'd50);
    imem[1] = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd9);
    imem[2] = ins(4'hB, 4'd0, 4'd0, 4'd1, 16'd1);
    imem[3] = ins(4'hB, 4'd0, 4'd0, 4'd1, 16'd2);
    imem[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    do_reset("r34a");
    run(3, "r34a");
    chk("r34 pre store", obs_data[2], 32'd9);
    do_reset("r34mid");
    run(2, "r34b");
    chk("r34 r1 zero addr", obs_addr[0], 32'd50);
    chk("r34 r1 zero data", obs_data[0], 32'd0);

    // Random programs against the model
    for (int t = 0; t < 4; t++) begin
      gen_prog(40);
      do_reset($sformatf("rnd%0d", t));
      run(70, $sformatf("rnd%0d", t));
      mism = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) mism++;
      chk($sformatf("rnd%0d dmem", t), mism, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have parameter REGS, default 16, number of 32-bit general registers (R0..R15).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port inst_mem_data_i, input, 32 bits: instruction word at inst_mem_address_o, valid in the same cycle.
REQ-005 SHALL have port inst_mem_address_o, output, 32 bits: current PC as a word index.
REQ-006 SHALL have port data_mem_out_data_i, input, 32 bits: load data at data_mem_address_o, valid in the same cycle.
REQ-007 SHALL have port data_mem_address_o, output, 32 bits: data word address.
REQ-008 SHALL have port data_mem_in_data_o, output, 32 bits: store data.
REQ-009 SHALL have port data_mem_WE_o, output, 1 bit: store strobe; memory writes on the rising CLK edge while high.

Function
REQ-010 SHALL be a single-cycle processor: one instruction fetched, executed and retired per CLK cycle.
REQ-011 SHALL decode instruction fields as opcode [31:28], rd [27:24], rs1 [23:20], rs2 [19:16], imm [15:0]; simm is imm sign-extended to 32 bits.
REQ-012 SHALL hardwire R0 to zero: reads return 0 and writes are ignored.
REQ-013 SHALL implement opcodes 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL (rs1<<rs2[4:0]) and 7 SRL (logical, rs1>>rs2[4:0]), each writing rd.
REQ-014 SHALL implement 8 ADDI (rd=rs1+simm) and 9 LUI (rd={imm,16'h0}).
REQ-015 SHALL implement A LW: rd=data_mem_out_data_i, with address rs1+simm.
REQ-016 SHALL implement B SW: address rs1+simm, data_mem_in_data_o=rs2, data_mem_WE_o=1.
REQ-017 SHALL implement C BEQ and D BNE: if taken, PC=PC+1+simm, otherwise PC=PC+1.
REQ-018 SHALL implement E JMP: PC={16'h0,imm}.
REQ-019 SHALL implement F HALT: PC holds and no register or memory write occurs until reset.
REQ-020 SHALL, for every other instruction, advance PC by 1 per cycle, wrapping modulo 2^32.
REQ-021 SHALL perform all arithmetic modulo 2^32, ignoring overflow and carry.
REQ-022 SHALL assert data_mem_WE_o combinationally, only during an SW cycle and never while RST=1.
REQ-023 SHALL drive data_mem_address_o with rs1+simm for every instruction, and data_mem_in_data_o with rs2 for every instruction.
REQ-024 SHALL, for a register read in the same cycle as a write to that register, return the old value; the new value is visible the next cycle.
REQ-025 SHALL, for a branch or JMP to its own address, loop without any special handling.

Reset
REQ-026 SHALL, while RST=1, hold PC=0, clear R1..R15 to 0, and force data_mem_WE_o=0 and the halted flag to 0, asynchronously.
REQ-027 SHALL, on RST assertion in mid-program, abandon the current instruction with no register or memory write.
REQ-028 SHALL fetch the first instruction from address 0 in the first cycle after RST falls.

Verification
REQ-029 SHALL pass: reset then ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; SW R3,[R0+10] -> WE=1 in cycle 4 with address 10 and data 12.
REQ-030 SHALL pass: LUI R1,0xFFFF; ADDI R1,R1,-1; SW R1,[R0+0] -> stored data 0xFFFEFFFF.
REQ-031 SHALL pass: memory word 20=0x1234; LW R4,[R0+20]; SW R4,[R0+21] -> write of 0x1234 to address 21.
REQ-032 SHALL pass: BNE R1,R0,-1 at PC 3 with R1=1 -> PC stays 3 each cycle; with R1=0 -> PC advances to 4.
REQ-033 SHALL pass: HALT at PC 6 -> inst_mem_address_o stays 6 and WE stays 0 for 10 cycles.
REQ-034 SHALL pass: RST pulsed mid-run between two SW instructions -> no WE during reset, PC=0 after release, registers read 0.
